crypto_test_incoming_reader: RTL and testbench

//  Avalon-MM read master that drains the 4096x32 incoming-memory RAM.

---
 rtl/crypto_test_incoming_reader_if.sv | 37 +++
 rtl/crypto_test_incoming_reader.sv | 180 ++++++++++++++++++
 tb/tb_crypto_test_incoming_reader.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/crypto_test_incoming_reader_if.sv
// Bus bundle for the incoming-memory reader: the Avalon-MM read port toward the
// incoming-memory RAM and the Avalon-ST source toward the crypto core.
interface crypto_test_incoming_reader_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  // Avalon-MM read port (fixed 1-cycle read latency, no waitrequest)
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_chipselect;
  logic                  mem_write;
  logic [3:0]            mem_byteenable;
  logic                  mem_clken;
  logic [DATA_WIDTH-1:0] mem_readdata;

  // Avalon-ST source
  logic [DATA_WIDTH-1:0] src_data;
  logic                  src_valid;
  logic                  src_ready;
  logic                  src_sop;
  logic                  src_eop;

  // The reader drives the memory address side and the stream source
  modport master (
    output mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
    input  mem_readdata,
    output src_data, src_valid, src_sop, src_eop,
    input  src_ready
  );

  // Memory plus stream sink seen from the other end
  modport slave (
    input  mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
    output mem_readdata,
    input  src_data, src_valid, src_sop, src_eop,
    output src_ready
  );
endinterface

// File: rtl/crypto_test_incoming_reader.sv
// Read master that drains word_count words of the incoming-memory RAM starting at
// base_addr (wrapping at the top of memory) and streams them out as one packet.
// Reads are only issued when the output FIFO is guaranteed a free slot for the
// returning word, so the FIFO can never overflow regardless of src_ready.
module crypto_test_incoming_reader #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  output logic                  busy,
  output logic                  done,
  crypto_test_incoming_reader_if.master bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W:0] DEPTH_V = (LVL_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_FIN
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;       // next address to issue
  logic [ADDR_WIDTH:0]   count_q, count_d;     // latched word_count
  logic [ADDR_WIDTH:0]   issued_q, issued_d;   // reads issued so far
  logic [ADDR_WIDTH:0]   beat_q, beat_d;       // beats delivered so far
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  cs_q, cs_d;           // read on the bus this cycle
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic                  rvalid_q, rvalid_d;   // mem_readdata valid this cycle
  logic [LVL_W-1:0]      level_q, level_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;

  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

  logic                  push;
  logic                  pop;
  logic                  src_valid;
  logic [LVL_W:0]        committed;
  logic                  rd_req;

  // Datapath handshakes and credit check
  always_comb begin
    push      = rvalid_q;
    src_valid = (level_q != '0);
    pop       = src_valid && bus.src_ready;
    // Slots already spoken for: stored words plus reads on the bus or returning.
    // A pop this cycle is deliberately not counted as freeing a slot yet.
    committed = (LVL_W + 1)'(level_q) + (LVL_W + 1)'(cs_q) + (LVL_W + 1)'(rvalid_q);
    rd_req    = (state_q == ST_ISSUE) && (issued_q != count_q) && (committed < DEPTH_V);
  end

  // Next-state logic for the FSM, read issue and FIFO bookkeeping
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    count_d  = count_q;
    issued_d = issued_q;
    beat_d   = beat_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cs_d     = rd_req;
    maddr_d  = maddr_q;
    rvalid_d = cs_q;
    level_d  = level_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          count_d  = word_count;
          addr_d   = base_addr;
          issued_d = '0;
          beat_d   = '0;
          busy_d   = 1'b1;
          state_d  = (word_count != '0) ? ST_ISSUE : ST_FIN;
        end
      end
      ST_ISSUE: begin
        if (rd_req) begin
          maddr_d  = addr_q;
          addr_d   = addr_q + 1'b1;   // wraps naturally at the top of memory
          issued_d = issued_q + 1'b1;
          if (issued_q + 1'b1 == count_q) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!cs_q && !rvalid_q && (level_q == '0)) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      beat_d   = beat_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Control and status registers; reset aborts any transfer in progress
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      count_q  <= '0;
      issued_q <= '0;
      beat_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cs_q     <= 1'b0;
      maddr_q  <= '0;
      rvalid_q <= 1'b0;
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      issued_q <= issued_d;
      beat_q   <= beat_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cs_q     <= cs_d;
      maddr_q  <= maddr_d;
      rvalid_q <= rvalid_d;
      level_q  <= level_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage: capture the returning memory word
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= bus.mem_readdata;
    end
  end

  assign busy               = busy_q;
  assign done               = done_q;
  assign bus.mem_address    = maddr_q;
  assign bus.mem_chipselect = cs_q;
  assign bus.mem_write      = 1'b0;
  assign bus.mem_byteenable = 4'hF;
  assign bus.mem_clken      = 1'b1;
  assign bus.src_valid      = src_valid;
  assign bus.src_data       = src_valid ? fifo_mem[rd_ptr_q] : '0;
  assign bus.src_sop        = src_valid && (beat_q == '0);
  assign bus.src_eop        = src_valid && (beat_q == count_q - 1'b1);

endmodule

// File: tb/tb_crypto_test_incoming_reader.sv
// Directed bench for crypto_test_incoming_reader: memory model, stream monitor,
// and a linear sequence of transfers with hand-computed expectations.
module tb_crypto_test_incoming_reader;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [11:0] base_addr;
  logic [12:0] word_count;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  crypto_test_incoming_reader_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();

  crypto_test_incoming_reader #(
    .ADDR_WIDTH(12),
    .DATA_WIDTH(32),
    .FIFO_DEPTH(4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: word at address a is C0DE_0000 | a
  function automatic logic [31:0] dval(input logic [11:0] a);
    return 32'hC0DE_0000 | {20'h0, a};
  endfunction

  // RAM model with 1-cycle read latency
  always @(posedge clk) begin
    if (bus.mem_chipselect) bus.mem_readdata <= dval(bus.mem_address);
  end

  // Monitor: record reads, beats and done pulses on the falling edge
  logic [11:0] cs_addr[$];
  int          cs_cyc[$];
  logic [31:0] bt_data[$];
  logic        bt_sop[$];
  logic        bt_eop[$];
  int          bt_cyc[$];
  int          done_cnt = 0;
  int          cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (bus.mem_chipselect) begin
      cs_addr.push_back(bus.mem_address);
      cs_cyc.push_back(cyc);
    end
    if (bus.src_valid && bus.src_ready) begin
      bt_data.push_back(bus.src_data);
      bt_sop.push_back(bus.src_sop);
      bt_eop.push_back(bus.src_eop);
      bt_cyc.push_back(cyc);
    end
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    cs_addr.delete(); cs_cyc.delete();
    bt_data.delete(); bt_sop.delete(); bt_eop.delete(); bt_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start(input logic [11:0] b, input logic [12:0] n);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; word_count = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
    repeat (3) @(posedge clk);
  endtask

  // Check a finished packet: reads, beats in order, framing, one done
  task automatic check_packet(input string tag, input logic [11:0] b, input int n);
    logic [11:0] a;
    check({tag, "_reads"}, 64'(cs_addr.size()), 64'(n));
    check({tag, "_beats"}, 64'(bt_data.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      a = b + 12'(i);
      check($sformatf("%s_addr%0d", tag, i), 64'(cs_addr[i]), 64'(a));
      check($sformatf("%s_data%0d", tag, i), 64'(bt_data[i]), 64'(dval(a)));
      check($sformatf("%s_sop%0d", tag, i), 64'(bt_sop[i]), 64'(i == 0));
      check($sformatf("%s_eop%0d", tag, i), 64'(bt_eop[i]), 64'(i == n - 1));
    end
    check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    reset_n        = 1'b0;
    start          = 1'b0;
    base_addr      = '0;
    word_count     = '0;
    bus.src_ready  = 1'b0;
    bus.mem_readdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_valid", 64'(bus.src_valid), 64'd0);
    check("rst_sop", 64'(bus.src_sop), 64'd0);
    check("rst_eop", 64'(bus.src_eop), 64'd0);
    check("rst_cs", 64'(bus.mem_chipselect), 64'd0);
    check("rst_addr", 64'(bus.mem_address), 64'd0);
    check("const_write", 64'(bus.mem_write), 64'd0);
    check("const_be", 64'(bus.mem_byteenable), 64'hF);
    check("const_clken", 64'(bus.mem_clken), 64'd1);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // T1: basic packet, always ready
    clear_log();
    bus.src_ready = 1'b1;
    pulse_start(12'h010, 13'd4);
    wait_done("t1", 60);
    check_packet("t1", 12'h010, 4);
    check("t1_cs_consecutive", 64'(cs_cyc[3] - cs_cyc[0]), 64'd3);
    check("t1_first_latency", 64'(bt_cyc[0] - cs_cyc[0]), 64'd2);

    // T2: wrap at the top of memory
    clear_log();
    pulse_start(12'hFFE, 13'd4);
    wait_done("t2", 60);
    check_packet("t2", 12'hFFE, 4);

    // T3: backpressure stalls issue at FIFO depth
    clear_log();
    bus.src_ready = 1'b0;
    pulse_start(12'h100, 13'd10);
    repeat (19) @(posedge clk);
    @(negedge clk);
    check("t3_stall_reads", 64'(cs_addr.size()), 64'd4);
    check("t3_stall_beats", 64'(bt_data.size()), 64'd0);
    check("t3_hold_valid", 64'(bus.src_valid), 64'd1);
    check("t3_hold_data", 64'(bus.src_data), 64'(dval(12'h100)));
    check("t3_hold_sop", 64'(bus.src_sop), 64'd1);
    check("t3_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    bus.src_ready = 1'b1;
    wait_done("t3", 80);
    check_packet("t3", 12'h100, 10);

    // T4: zero-length transfer
    clear_log();
    @(posedge clk); #1;
    start = 1'b1; base_addr = 12'h055; word_count = 13'd0;
    @(negedge clk);
    check("t4_busy_c0", 64'(busy), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("t4_busy_c1", 64'(busy), 64'd1);
    check("t4_done_c1", 64'(done), 64'd0);
    @(negedge clk);
    check("t4_busy_c2", 64'(busy), 64'd0);
    check("t4_done_c2", 64'(done), 64'd1);
    @(negedge clk);
    check("t4_done_c3", 64'(done), 64'd0);
    repeat (3) @(posedge clk);
    check("t4_reads", 64'(cs_addr.size()), 64'd0);
    check("t4_beats", 64'(bt_data.size()), 64'd0);
    check("t4_done_cnt", 64'(done_cnt), 64'd1);

    // T5: random ready, reset after beat 3, then a clean transfer
    clear_log();
    pulse_start(12'h300, 13'd8);
    for (int i = 0; i < 200 && bt_data.size() < 4; i++) begin
      bus.src_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    check("t5_beats_before_rst", 64'(bt_data.size()), 64'd4);
    #1;
    reset_n = 1'b0;
    #1;
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_done", 64'(done), 64'd0);
    check("t5_rst_valid", 64'(bus.src_valid), 64'd0);
    check("t5_rst_sop", 64'(bus.src_sop), 64'd0);
    check("t5_rst_eop", 64'(bus.src_eop), 64'd0);
    check("t5_rst_cs", 64'(bus.mem_chipselect), 64'd0);
    check("t5_rst_addr", 64'(bus.mem_address), 64'd0);
    check("t5_rst_data", 64'(bus.src_data), 64'd0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    bus.src_ready = 1'b1;
    repeat (5) @(posedge clk);
    check("t5_no_done_abort", 64'(done_cnt), 64'd0);
    clear_log();
    pulse_start(12'h020, 13'd2);
    wait_done("t5b", 60);
    check_packet("t5b", 12'h020, 2);

    // T6: start while busy is ignored
    clear_log();
    pulse_start(12'h200, 13'd6);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 12'h400; word_count = 13'd2;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("t6", 80);
    repeat (10) @(posedge clk);
    check_packet("t6", 12'h200, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
